// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_e;

    // Result encoding as {gt, eq, lt}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice; eq is implied by neither flag.
module digit_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, start/busy/done handshake.
module comparator_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 a_gt_b,
    output logic                                 a_eq_b,
    output logic                                 a_lt_b,
    output logic [cnt_width(WIDTH, DIGIT)-1:0]   cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NDIG);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [CW-1:0]     cnt_q, cnt_d, cycles_q, cycles_d;
    logic              diff_q, diff_d, dgt_q, dgt_d;
    logic              done_q, done_d;
    logic              gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic              dig_gt, dig_lt, dig_diff;

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a  (a_sh_q[WIDTH-1 -: DIGIT]),
        .b  (b_sh_q[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    assign dig_diff = dig_gt | dig_lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            diff_q   <= 1'b0;
            dgt_q    <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            diff_q   <= diff_d;
            dgt_q    <= dgt_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        diff_d   = diff_q;
        dgt_d    = dgt_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping both MSBs maps two's-complement order onto unsigned order
                    a_sh_d = a;
                    b_sh_d = b;
                    if (signed_mode) begin
                        a_sh_d[WIDTH-1] = ~a[WIDTH-1];
                        b_sh_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    cnt_d   = CW'(1);
                    diff_d  = 1'b0;
                    dgt_d   = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                cnt_d  = cnt_q + 1'b1;
                if (!diff_q && dig_diff) begin
                    diff_d = 1'b1;
                    dgt_d  = dig_gt;
                end
                if ((EARLY_EXIT != 0) && dig_diff) begin
                    gt_d     = dig_gt;
                    lt_d     = dig_lt;
                    eq_d     = 1'b0;
                    cycles_d = cnt_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == LAST) begin
                    // The first recorded difference wins over later digits
                    if (diff_q) begin
                        gt_d = dgt_q;
                        lt_d = ~dgt_q;
                        eq_d = 1'b0;
                    end else begin
                        gt_d = dig_gt;
                        lt_d = dig_lt;
                        eq_d = ~dig_diff;
                    end
                    cycles_d = cnt_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == COMPARE);
        done   = done_q;
        a_gt_b = gt_q;
        a_eq_b = eq_q;
        a_lt_b = lt_q;
        cycles = cycles_q;
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Directed-vector bench for comparator_seq: early-exit, fixed-latency and 2-bit exhaustive builds.
module tb_comparator_seq;
    import cmp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Default build: WIDTH=8, DIGIT=2, EARLY_EXIT=1
    logic       start_d = 1'b0, sm_d = 1'b0;
    logic [7:0] a_d = '0, b_d = '0;
    logic       busy_d, done_d, gt_d, eq_d, lt_d;
    logic [2:0] cyc_d;

    // Fixed-latency build: WIDTH=8, DIGIT=2, EARLY_EXIT=0
    logic       start_f = 1'b0, sm_f = 1'b0;
    logic [7:0] a_f = '0, b_f = '0;
    logic       busy_f, done_f, gt_f, eq_f, lt_f;
    logic [2:0] cyc_f;

    // Bit-serial build: WIDTH=2, DIGIT=1, EARLY_EXIT=1
    logic       start_s = 1'b0, sm_s = 1'b0;
    logic [1:0] a_s = '0, b_s = '0;
    logic       busy_s, done_s, gt_s, eq_s, lt_s;
    logic [1:0] cyc_s;

    comparator_seq #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .signed_mode(sm_d), .a(a_d), .b(b_d),
        .busy(busy_d), .done(done_d), .a_gt_b(gt_d), .a_eq_b(eq_d), .a_lt_b(lt_d), .cycles(cyc_d));

    comparator_seq #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_f (
        .clk(clk), .rst_n(rst_n), .start(start_f), .signed_mode(sm_f), .a(a_f), .b(b_f),
        .busy(busy_f), .done(done_f), .a_gt_b(gt_f), .a_eq_b(eq_f), .a_lt_b(lt_f), .cycles(cyc_f));

    comparator_seq #(.WIDTH(2), .DIGIT(1), .EARLY_EXIT(1)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .signed_mode(sm_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .a_gt_b(gt_s), .a_eq_b(eq_s), .a_lt_b(lt_s), .cycles(cyc_s));

    // done and busy must never be high together on any build
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((done_d && busy_d) || (done_f && busy_f) || (done_s && busy_s)) begin
                failures++;
                $display("FAIL done_busy_overlap: d=%b%b f=%b%b s=%b%b, required never both 1",
                         done_d, busy_d, done_f, busy_f, done_s, busy_s);
            end
        end
    end

    // Each go_* task starts at a negedge, and returns at the negedge where done is seen.
    // lat = edges from the start edge to the decision edge, -1 on timeout.
    task automatic go_d(input logic [7:0] ai, input logic [7:0] bi, input logic sm, output int lat);
        start_d = 1'b1; a_d = ai; b_d = bi; sm_d = sm;
        @(negedge clk);
        start_d = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done_d) begin lat = n; break; end
        end
    endtask

    task automatic go_f(input logic [7:0] ai, input logic [7:0] bi, input logic sm, output int lat);
        start_f = 1'b1; a_f = ai; b_f = bi; sm_f = sm;
        @(negedge clk);
        start_f = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done_f) begin lat = n; break; end
        end
    endtask

    task automatic go_s(input logic [1:0] ai, input logic [1:0] bi, input logic sm, output int lat);
        start_s = 1'b1; a_s = ai; b_s = bi; sm_s = sm;
        @(negedge clk);
        start_s = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done_s) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy_d, done_d, gt_d, eq_d, lt_d, cyc_d} !== 8'b0) begin
            failures++;
            $display("FAIL reset_d: got %b, required 0", {busy_d, done_d, gt_d, eq_d, lt_d, cyc_d});
        end
        checks++;
        if ({busy_f, done_f, gt_f, eq_f, lt_f, cyc_f} !== 8'b0) begin
            failures++;
            $display("FAIL reset_f: got %b, required 0", {busy_f, done_f, gt_f, eq_f, lt_f, cyc_f});
        end
        checks++;
        if ({busy_s, done_s, gt_s, eq_s, lt_s, cyc_s} !== 7'b0) begin
            failures++;
            $display("FAIL reset_s: got %b, required 0", {busy_s, done_s, gt_s, eq_s, lt_s, cyc_s});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_equal;
        int lat;
        go_d(8'hA5, 8'hA5, 1'b0, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL equal_latency: got %0d, required 4", lat); end
        checks++;
        if ({gt_d, eq_d, lt_d} !== RES_EQ) begin
            failures++; $display("FAIL equal_result: got %b, required %b", {gt_d, eq_d, lt_d}, RES_EQ);
        end
        checks++;
        if (cyc_d !== 3'd4) begin failures++; $display("FAIL equal_cycles: got %0d, required 4", cyc_d); end
    endtask

    task automatic test_early_exit;
        int lat;
        go_d(8'h80, 8'h7F, 1'b0, lat);
        checks++;
        if (lat !== 1 || {gt_d, eq_d, lt_d} !== RES_GT || cyc_d !== 3'd1) begin
            failures++;
            $display("FAIL early_unsigned: got lat=%0d res=%b cyc=%0d, required lat=1 res=%b cyc=1",
                     lat, {gt_d, eq_d, lt_d}, cyc_d, RES_GT);
        end
        go_d(8'h80, 8'h7F, 1'b1, lat);
        checks++;
        if (lat !== 1 || {gt_d, eq_d, lt_d} !== RES_LT || cyc_d !== 3'd1) begin
            failures++;
            $display("FAIL early_signed: got lat=%0d res=%b cyc=%0d, required lat=1 res=%b cyc=1",
                     lat, {gt_d, eq_d, lt_d}, cyc_d, RES_LT);
        end
        // -16 vs -12: MSBs equal, differ at digit 3
        go_d(8'hF0, 8'hF4, 1'b1, lat);
        checks++;
        if (lat !== 3 || {gt_d, eq_d, lt_d} !== RES_LT || cyc_d !== 3'd3) begin
            failures++;
            $display("FAIL early_signed_neg: got lat=%0d res=%b cyc=%0d, required lat=3 res=%b cyc=3",
                     lat, {gt_d, eq_d, lt_d}, cyc_d, RES_LT);
        end
        go_d(8'hFE, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 1 || {gt_d, eq_d, lt_d} !== RES_GT) begin
            failures++;
            $display("FAIL early_fe_01_unsigned: got lat=%0d res=%b, required lat=1 res=%b",
                     lat, {gt_d, eq_d, lt_d}, RES_GT);
        end
    endtask

    task automatic test_last_digit;
        int lat;
        go_d(8'hA4, 8'hA5, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_d, eq_d, lt_d} !== RES_LT || cyc_d !== 3'd4) begin
            failures++;
            $display("FAIL last_digit: got lat=%0d res=%b cyc=%0d, required lat=4 res=%b cyc=4",
                     lat, {gt_d, eq_d, lt_d}, cyc_d, RES_LT);
        end
    endtask

    task automatic test_fixed_latency;
        int lat;
        go_f(8'h80, 8'h7F, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_f, eq_f, lt_f} !== RES_GT || cyc_f !== 3'd4) begin
            failures++;
            $display("FAIL fixed_unsigned: got lat=%0d res=%b cyc=%0d, required lat=4 res=%b cyc=4",
                     lat, {gt_f, eq_f, lt_f}, cyc_f, RES_GT);
        end
        go_f(8'h80, 8'h7F, 1'b1, lat);
        checks++;
        if (lat !== 4 || {gt_f, eq_f, lt_f} !== RES_LT) begin
            failures++;
            $display("FAIL fixed_signed: got lat=%0d res=%b, required lat=4 res=%b",
                     lat, {gt_f, eq_f, lt_f}, RES_LT);
        end
        // First difference at digit 1 is gt; later digits favour b and must not override
        go_f(8'h40, 8'h3F, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_f, eq_f, lt_f} !== RES_GT) begin
            failures++;
            $display("FAIL fixed_first_diff: got lat=%0d res=%b, required lat=4 res=%b",
                     lat, {gt_f, eq_f, lt_f}, RES_GT);
        end
        go_f(8'h3C, 8'h3C, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_f, eq_f, lt_f} !== RES_EQ) begin
            failures++;
            $display("FAIL fixed_equal: got lat=%0d res=%b, required lat=4 res=%b",
                     lat, {gt_f, eq_f, lt_f}, RES_EQ);
        end
    endtask

    task automatic test_handshake;
        logic [7:0] va [6];
        logic [7:0] vb [6];
        va = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'hAA, 8'hC0};
        vb = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'hAA, 8'h00};
        sm_d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 1 && i <= 4) begin
                checks++;
                if (busy_d !== 1'b1 || done_d !== 1'b0) begin
                    failures++;
                    $display("FAIL hs_busy_%0d: got busy=%b done=%b, required busy=1 done=0", i, busy_d, done_d);
                end
            end
            if (i == 5) begin
                checks++;
                if (done_d !== 1'b1 || {gt_d, eq_d, lt_d} !== RES_LT || cyc_d !== 3'd4) begin
                    failures++;
                    $display("FAIL hs_first_done: got done=%b res=%b cyc=%0d, required done=1 res=%b cyc=4",
                             done_d, {gt_d, eq_d, lt_d}, cyc_d, RES_LT);
                end
            end
            start_d = 1'b1; a_d = va[i]; b_d = vb[i];
            @(negedge clk);
        end
        start_d = 1'b0;
        checks++;
        if (busy_d !== 1'b1 || done_d !== 1'b0 || {gt_d, eq_d, lt_d} !== RES_LT) begin
            failures++;
            $display("FAIL hs_hold: got busy=%b done=%b res=%b, required busy=1 done=0 res=%b",
                     busy_d, done_d, {gt_d, eq_d, lt_d}, RES_LT);
        end
        @(negedge clk);
        checks++;
        if (done_d !== 1'b1 || {gt_d, eq_d, lt_d} !== RES_GT || cyc_d !== 3'd1) begin
            failures++;
            $display("FAIL hs_second_done: got done=%b res=%b cyc=%0d, required done=1 res=%b cyc=1",
                     done_d, {gt_d, eq_d, lt_d}, cyc_d, RES_GT);
        end
    endtask

    // Called while done is high from the previous compare
    task automatic test_start_in_done;
        int lat;
        go_d(8'h01, 8'h02, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_d, eq_d, lt_d} !== RES_LT) begin
            failures++;
            $display("FAIL start_in_done: got lat=%0d res=%b, required lat=4 res=%b",
                     lat, {gt_d, eq_d, lt_d}, RES_LT);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_d = 1'b1; a_d = 8'h55; b_d = 8'h55; sm_d = 1'b0;
        @(negedge clk);
        start_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_d, done_d, gt_d, eq_d, lt_d, cyc_d} !== 8'b0) begin
            failures++;
            $display("FAIL reset_mid_clear: got %b, required 0", {busy_d, done_d, gt_d, eq_d, lt_d, cyc_d});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_d !== 1'b0 || busy_d !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_idle_%0d: got done=%b busy=%b, required 0 0", i, done_d, busy_d);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        go_d(8'h55, 8'h55, 1'b0, lat);
        checks++;
        if (lat !== 4 || {gt_d, eq_d, lt_d} !== RES_EQ || cyc_d !== 3'd4) begin
            failures++;
            $display("FAIL reset_mid_fresh: got lat=%0d res=%b cyc=%0d, required lat=4 res=%b cyc=4",
                     lat, {gt_d, eq_d, lt_d}, cyc_d, RES_EQ);
        end
    endtask

    task automatic test_sweep;
        int lat, sa, sb;
        logic [2:0] exp_res;
        for (int sm = 0; sm < 2; sm++) begin
            for (int ai = 0; ai < 4; ai++) begin
                for (int bi = 0; bi < 4; bi++) begin
                    sa = (sm == 1 && ai >= 2) ? ai - 4 : ai;
                    sb = (sm == 1 && bi >= 2) ? bi - 4 : bi;
                    exp_res = (sa > sb) ? RES_GT : (sa == sb) ? RES_EQ : RES_LT;
                    go_s(2'(ai), 2'(bi), sm[0], lat);
                    checks++;
                    if (lat < 1 || {gt_s, eq_s, lt_s} !== exp_res) begin
                        failures++;
                        $display("FAIL sweep sm=%0d a=%0d b=%0d: got lat=%0d res=%b, required res=%b",
                                 sm, ai, bi, lat, {gt_s, eq_s, lt_s}, exp_res);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_equal;
        test_early_exit;
        test_last_digit;
        test_fixed_latency;
        test_handshake;
        test_start_in_done;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
